// File: rtl/bbox_pkg.sv
// Shared types and default geometry for the bounding-box frame sequencer.
package bbox_pkg;

  localparam int DEF_IMG_W = 100;
  localparam int DEF_IMG_H = 100;
  localparam int DEF_NPIX  = DEF_IMG_W * DEF_IMG_H;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } bbox_state_t;

  typedef struct packed {
    logic [7:0] xmin;
    logic [7:0] xmax;
    logic [7:0] ymin;
    logic [7:0] ymax;
  } bbox_coord_t;

endpackage

// File: rtl/bbox_watchdog.sv
// RUN-cycle watchdog: cleared by load_i, counts while en_i, flags expiry on the
// TIMEOUT_CYC-th counted cycle so the FSM leaves RUN at the edge ending it.
module bbox_watchdog #(
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/bbox_frame_sequencer.sv
// Owns the image RAM port, launches the bbox engine on go and latches its result.
// Optional RUN timeout abort is compiled in with BBOX_TIMEOUT_EN.
module bbox_frame_sequencer
  import bbox_pkg::*;
#(
  parameter int IMG_W       = DEF_IMG_W,
  parameter int IMG_H       = DEF_IMG_H,
  parameter int NPIX        = IMG_W * IMG_H,
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              go,
  output logic              busy,
  output logic              result_valid,
  output logic              error,
  output logic [31:0]       coordinates,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wrdata,
  input  logic [7:0]        ram_rddata,
  output logic              bb_start,
  input  logic              bb_done,
  input  logic [ADDR_W-1:0] bb_addr,
  output logic [7:0]        bb_rddata,
  input  logic [7:0]        bb_xmin,
  input  logic [7:0]        bb_xmax,
  input  logic [7:0]        bb_ymin,
  input  logic [7:0]        bb_ymax
);

  // One extra bit so NPIX == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] NPIX_LIM = (ADDR_W + 1)'(NPIX);

  bbox_state_t state_q, state_d;
  logic        rv_q, rv_d;
  logic        err_q, err_d;
  bbox_coord_t coord_q, coord_d;
  logic        timeout;

`ifdef BBOX_TIMEOUT_EN
  bbox_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk_i    (CLOCK_50),
    .reset_i  (reset),
    .load_i   (state_q == START),
    .en_i     (state_q == RUN),
    .expire_o (timeout)
  );
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    rv_d    = rv_q;
    err_d   = err_q;
    coord_d = coord_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d = START;
          rv_d    = 1'b0;
          err_d   = 1'b0;
        end
      end
      START: state_d = RUN;
      RUN: begin
        // A completion in the expiry cycle still counts as a good result.
        if (bb_done) begin
          coord_d = '{xmin: bb_xmin, xmax: bb_xmax, ymin: bb_ymin, ymax: bb_ymax};
          rv_d    = 1'b1;
          state_d = IDLE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= IDLE;
      rv_q    <= 1'b0;
      err_q   <= 1'b0;
      coord_q <= '0;
    end else begin
      state_q <= state_d;
      rv_q    <= rv_d;
      err_q   <= err_d;
      coord_q <= coord_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign bb_start     = (state_q == START);
  assign result_valid = rv_q;
  assign error        = err_q;
  assign coordinates  = coord_q;

  assign ram_addr   = (state_q == IDLE) ? wr_addr : bb_addr;
  assign ram_we     = (state_q == IDLE) && wr_en && ({1'b0, wr_addr} < NPIX_LIM);
  assign ram_wrdata = wr_data;
  assign bb_rddata  = ram_rddata;

endmodule

// File: tb/tb_bbox_frame_sequencer.sv
// Directed bench for bbox_frame_sequencer with a behavioural RAM and scoreboard queues.
module tb_bbox_frame_sequencer;

  localparam int ADDR_W = 14;

  logic              CLOCK_50;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              go;
  logic              busy;
  logic              result_valid;
  logic              error;
  logic [31:0]       coordinates;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wrdata;
  logic [7:0]        ram_rddata;
  logic              bb_start;
  logic              bb_done;
  logic [ADDR_W-1:0] bb_addr;
  logic [7:0]        bb_rddata;
  logic [7:0]        bb_xmin, bb_xmax, bb_ymin, bb_ymax;

  logic [7:0]  mem [0:16383];
  logic [31:0] exp_q [$];
  logic [7:0]  rd_q [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          start_cnt = 0;

  bbox_frame_sequencer #(
    .IMG_W       (100),
    .IMG_H       (100),
    .NPIX        (10000),
    .ADDR_W      (ADDR_W),
    .TIMEOUT_CYC (16)
  ) dut (
    .CLOCK_50     (CLOCK_50),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .go           (go),
    .busy         (busy),
    .result_valid (result_valid),
    .error        (error),
    .coordinates  (coordinates),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wrdata   (ram_wrdata),
    .ram_rddata   (ram_rddata),
    .bb_start     (bb_start),
    .bb_done      (bb_done),
    .bb_addr      (bb_addr),
    .bb_rddata    (bb_rddata),
    .bb_xmin      (bb_xmin),
    .bb_xmax      (bb_xmax),
    .bb_ymin      (bb_ymin),
    .bb_ymax      (bb_ymax)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Single-port RAM with one-cycle read latency.
  always @(posedge CLOCK_50) begin
    if (ram_we) mem[ram_addr] <= ram_wrdata;
    ram_rddata <= mem[ram_addr];
  end

  always @(posedge CLOCK_50) begin
    if (bb_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit exceeded");
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_result(input logic [7:0] x0, input logic [7:0] x1,
                            input logic [7:0] y0, input logic [7:0] y1);
    bb_done = 1'b1;
    bb_xmin = x0; bb_xmax = x1; bb_ymin = y0; bb_ymax = y1;
    exp_q.push_back({x0, x1, y0, y1});
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; go = 1'b0;
    bb_done = 1'b0; bb_addr = '0;
    bb_xmin = '0; bb_xmax = '0; bb_ymin = '0; bb_ymax = '0;
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_rv", result_valid, 0);
    chk("rst_err", error, 0);
    chk("rst_coord", coordinates, 0);
    chk("rst_start", bb_start, 0);
    chk("rst_we", ram_we, 0);
    reset = 1'b0;
    step();

    // Address range boundary
    wr_en = 1'b1; wr_addr = 14'd0; wr_data = 8'hFF; #1 chk("we_addr0", ram_we, 1); step();
    wr_addr = 14'd9999; #1 chk("we_addr9999", ram_we, 1); step();
    wr_addr = 14'd10000; #1 chk("we_addr10000", ram_we, 0); step();
    wr_en = 1'b0;
    chk("mem0", mem[0], 8'hFF);
    chk("mem9999", mem[9999], 8'hFF);
    chk("mem10000", mem[10000], 8'h00);

    // Preload 5,6,7, then write addr 3 in the same cycle as go
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_addr = ADDR_W'(i); wr_data = 8'(5 + i); step();
    end
    wr_addr = 14'd3; wr_data = 8'h33; go = 1'b1;
    step();
    wr_en = 1'b0; go = 1'b0;
    chk("start_hi", bb_start, 1);
    chk("start_busy", busy, 1);
    step();
    chk("start_lo", bb_start, 0);
    for (int c = 0; c < 20; c++) begin
      if (c >= 1 && c <= 4) chk("rddata", bb_rddata, rd_q.pop_front());
      if (c < 4) begin
        bb_addr = ADDR_W'(c);
        rd_q.push_back((c == 3) ? 8'h33 : 8'(5 + c));
      end
      if (c >= 5 && c < 10) begin
        go = 1'b1; wr_en = 1'b1; wr_addr = 14'd0; wr_data = 8'hAA;
        #1 chk("we_in_run", ram_we, 0);
      end else begin
        go = 1'b0; wr_en = 1'b0;
      end
      if (c == 19) set_result(8'd10, 8'd50, 8'd20, 8'd60);
      step();
    end
    bb_done = 1'b0; go = 1'b0; wr_en = 1'b0;
    chk("run1_coord", coordinates, exp_q.pop_front());
    chk("run1_rv", result_valid, 1);
    chk("run1_busy", busy, 0);
    chk("run1_starts", start_cnt, 1);
    chk("run1_mem0_kept", mem[0], 8'h05);

    // Reset five cycles into RUN
    go = 1'b1; step(); go = 1'b0; step();
    repeat (5) step();
    reset = 1'b1; step(); reset = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_rv", result_valid, 0);
    chk("mid_rst_coord", coordinates, 0);
    chk("mid_rst_start", bb_start, 0);
    chk("mid_rst_mem3", mem[3], 8'h33);

    go = 1'b1; step(); go = 1'b0;
    chk("run2_start", bb_start, 1);
    step(); repeat (3) step();
    set_result(8'd1, 8'd2, 8'd3, 8'd4);
    step(); bb_done = 1'b0;
    chk("run2_coord", coordinates, exp_q.pop_front());
    chk("run2_rv", result_valid, 1);
    chk("run2_busy", busy, 0);
    chk("run2_starts", start_cnt, 3);

`ifdef BBOX_TIMEOUT_EN
    go = 1'b1; step(); go = 1'b0;
    chk("to_rv_clear", result_valid, 0);
    step();
    repeat (15) step();
    chk("to_busy_before", busy, 1);
    step();
    chk("to_err", error, 1);
    chk("to_busy", busy, 0);
    chk("to_rv", result_valid, 0);
    chk("to_coord_kept", coordinates, 32'h01020304);
    go = 1'b1; step(); go = 1'b0;
    chk("to_err_clear", error, 0);
    step();
    set_result(8'd7, 8'd8, 8'd9, 8'd10);
    step(); bb_done = 1'b0;
    chk("to_next_coord", coordinates, exp_q.pop_front());
`else
    chk("err_tied", error, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
